// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-driven initiator for an 8-bit combinational ALU
// Owns the register file and flag register; one command in flight, valid/ready on both sides.
module alu_sequencer #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [7:0]    cmd_imm,
    output logic [2:0]    alu_opcode,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    input  logic [7:0]    alu_out,
    input  logic [3:0]    alu_flag,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic [3:0]    rsp_flag,
    output logic [3:0]    flag_q,
    input  logic [AW-1:0] dbg_sel,
    output logic [7:0]    dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    regs [2**AW];
    logic [AW-1:0] rd_q;
    logic          accept;

    assign accept   = cmd_valid & cmd_ready;
    assign dbg_data = regs[dbg_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    next_state = cmd_ld ? RESP : EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operands are captured at accept, so rd == rs1/rs2 reads the pre-writeback value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                regs[i] <= 8'h00;
            end
            rd_q       <= '0;
            flag_q     <= 4'h0;
            alu_opcode <= 3'b000;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            rsp_data   <= 8'h00;
            rsp_flag   <= 4'h0;
        end else begin
            if (accept) begin
                if (cmd_ld) begin
                    regs[cmd_rd] <= cmd_imm;
                    rsp_data     <= cmd_imm;
                    rsp_flag     <= flag_q;
                end else begin
                    alu_opcode <= cmd_op;
                    alu_a      <= regs[cmd_rs1];
                    alu_b      <= regs[cmd_rs2];
                    rd_q       <= cmd_rd;
                end
            end
            if (state == EXEC) begin
                regs[rd_q] <= alu_out;
                flag_q     <= alu_flag;
                rsp_data   <= alu_out;
                rsp_flag   <= alu_flag;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural ALU
// Flags are {sign, zero, parity (1 = even ones), carry/borrow}.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic [3:0] alu_flag;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flag;
    logic [3:0] flag_q;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer #(.AW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ld     (cmd_ld),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_flag   (alu_flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flag   (rsp_flag),
        .flag_q     (flag_q),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in combinational ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHR, 111 SHL.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'h000;
        case (alu_opcode)
            3'b000: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: alu_wide = {1'b0, alu_a & alu_b};
            3'b011: alu_wide = {1'b0, alu_a | alu_b};
            3'b100: alu_wide = {1'b0, alu_a ^ alu_b};
            3'b101: alu_wide = {1'b0, ~alu_a};
            3'b110: alu_wide = {alu_a[0], 1'b0, alu_a[7:1]};
            default: alu_wide = {alu_a, 1'b0};
        endcase
        alu_out  = alu_wide[7:0];
        alu_flag = {alu_wide[7], (alu_wide[7:0] == 8'h00), ~(^alu_wide[7:0]), alu_wide[8]};
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Issues one command and returns at the first negedge where the response is presented.
    task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                          output logic [7:0] d, output logic [3:0] f);
        @(negedge clk);
        cmd_ld = ld; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", {7'b0, cmd_ready}, 8'h01);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        if (!ld) begin
            check("rsp_valid_exec", {7'b0, rsp_valid}, 8'h00);
            @(negedge clk);
        end
        check("rsp_valid_resp", {7'b0, rsp_valid}, 8'h01);
        d = rsp_data;
        f = rsp_flag;
    endtask

    logic [7:0] d;
    logic [3:0] f;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'b000;
        cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 8'h00;
        rsp_ready = 1'b1; dbg_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) check_reg("reset_reg", 2'(i), 8'h00);
        check("reset_flag_q", {4'h0, flag_q}, 8'h00);
        check("reset_cmd_ready", {7'b0, cmd_ready}, 8'h01);
        check("reset_rsp_valid", {7'b0, rsp_valid}, 8'h00);

        do_cmd(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'hFF, d, f);
        check("ld_r1_data", d, 8'hFF);
        check("ld_r1_flag", {4'h0, f}, 8'h00);
        do_cmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h01, d, f);
        do_cmd(1'b0, 3'b000, 2'd3, 2'd1, 2'd2, 8'h00, d, f);
        check("add_data", d, 8'h00);
        check("add_flag", {4'h0, f}, 8'h07);
        check("add_alu_a", alu_a, 8'hFF);
        check("add_alu_b", alu_b, 8'h01);
        check("add_flag_q", {4'h0, flag_q}, 8'h07);
        @(negedge clk);
        check_reg("add_r3", 2'd3, 8'h00);

        do_cmd(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, d, f);
        check("ld_keeps_flag", {4'h0, f}, 8'h07);
        do_cmd(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h07, d, f);
        do_cmd(1'b0, 3'b001, 2'd0, 2'd0, 2'd1, 8'h00, d, f);
        check("sub_data", d, 8'hFE);
        check("sub_flag", {4'h0, f}, 8'h09);
        check("sub_opcode", {5'b0, alu_opcode}, 8'h01);
        @(negedge clk);
        check_reg("sub_r0", 2'd0, 8'hFE);
        do_cmd(1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 8'h10, d, f);
        check("ld_after_sub_rsp_flag", {4'h0, f}, 8'h09);
        check("ld_after_sub_flag_q", {4'h0, flag_q}, 8'h09);

        do_cmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h81, d, f);
        do_cmd(1'b0, 3'b111, 2'd2, 2'd2, 2'd2, 8'h00, d, f);
        check("shl_data", d, 8'h02);
        check("shl_flag", {4'h0, f}, 8'h01);
        check("shl_alu_b", alu_b, 8'h81);
        @(negedge clk);
        check_reg("shl_r2", 2'd2, 8'h02);

        // Backpressure: XOR r1 = r0 ^ r3 = FE ^ 10 = EE, flags 1010; a stray command must be ignored.
        rsp_ready = 1'b0;
        do_cmd(1'b0, 3'b100, 2'd1, 2'd0, 2'd3, 8'h00, d, f);
        check("xor_data", d, 8'hEE);
        check("xor_flag", {4'h0, f}, 8'h0A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cmd_ld = 1'b1; cmd_rd = 2'd0; cmd_imm = 8'hAA; cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            check("hold_rsp_valid", {7'b0, rsp_valid}, 8'h01);
            check("hold_rsp_data", rsp_data, 8'hEE);
            check("hold_cmd_ready", {7'b0, cmd_ready}, 8'h00);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        check("release_cmd_ready", {7'b0, cmd_ready}, 8'h01);
        check_reg("stray_ignored_r0", 2'd0, 8'hFE);
        do_cmd(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h33, d, f);
        check("post_hold_ld", d, 8'h33);
        @(negedge clk);
        check_reg("post_hold_r0", 2'd0, 8'h33);

        // Reset while ADD r3 is in EXEC.
        @(negedge clk);
        cmd_ld = 1'b0; cmd_op = 3'b000; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reg("rst_exec_r3", 2'd3, 8'h00);
        check_reg("rst_exec_r0", 2'd0, 8'h00);
        check("rst_exec_flag_q", {4'h0, flag_q}, 8'h00);
        check("rst_exec_alu_a", alu_a, 8'h00);
        check("rst_exec_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
            check("post_rst_cmd_ready", {7'b0, cmd_ready}, 8'h01);
        end
        check_reg("post_rst_r3", 2'd3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven initiator for the 8-bit combinational ALU (3-bit opcode; operands a, b; 8-bit result; 4-bit flags).
- Owns a small register file and accepts one command at a time over a valid/ready handshake.
- For each command it either drives operands and an opcode to the ALU, or loads an immediate. It then writes the result back, latches the flags and returns a response under valid/ready.
- Sits between the instruction source and the ALU instance.

Parameters:
AW, 2, register index width; register file holds 2**AW entries of 8 bits (AW range 1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_ld  in  1  1 = load immediate, 0 = ALU operation
cmd_op  in  3  ALU opcode (ignored when cmd_ld=1)
cmd_rd  in  AW  destination register
cmd_rs1  in  AW  source register driven onto ALU a
cmd_rs2  in  AW  source register driven onto ALU b
cmd_imm  in  8  immediate for load
alu_opcode  out  3  registered opcode to ALU
alu_a  out  8  registered operand a
alu_b  out  8  registered operand b
alu_out  in  8  ALU result (combinational from alu_*)
alu_flag  in  4  ALU flags {sign, zero, parity, carry}
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_data  out  8  value written to rd
rsp_flag  out  4  flag register after the command
flag_q  out  4  current flag register
dbg_sel  in  AW  debug read index
dbg_data  out  8  regs[dbg_sel], combinational

Behaviour:
- Reset (async, rst_n=0):
  - All registers 0; flag_q 0; alu_opcode/alu_a/alu_b 0.
  - rsp_valid 0; rsp_data/rsp_flag 0; state IDLE.
  - Reset mid-command aborts it: no writeback, no response.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - cmd_ready=1.
  - On the accept edge (cmd_valid & cmd_ready), for an ALU command (cmd_ld=0):
    - alu_opcode<=cmd_op, alu_a<=regs[cmd_rs1], alu_b<=regs[cmd_rs2]; next state EXEC.
    - rd is latched internally.
  - On the accept edge for a load (cmd_ld=1):
    - regs[cmd_rd]<=cmd_imm, rsp_data<=cmd_imm, rsp_flag<=flag_q.
    - flag_q unchanged; alu_* hold previous values; next state RESP.
- EXEC (exactly 1 cycle):
  - At its closing edge: regs[rd]<=alu_out, flag_q<=alu_flag, rsp_data<=alu_out, rsp_flag<=alu_flag; next state RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_flag held stable.
  - On an edge with rsp_ready=1: go to IDLE, rsp_valid low the next cycle.
- Latency:
  - ALU command: accept at edge N, writeback at N+1, rsp_valid high from N+1.
  - Load: accept at edge N, rsp_valid high from N.
  - Minimum command spacing: 3 cycles (ALU) or 2 cycles (load) with rsp_ready tied high.
- Source reads happen at accept. rd == rs1/rs2 is legal; old values are used.
- A command accepted after RESP sees the prior writeback (no hazard, no forwarding needed).
- cmd_* sampled only on the accept edge; cmd_valid outside IDLE is ignored. Upstream holds fields while valid & !ready.
- All opcodes 000-111 are issued unchanged. For NOT (101) and shifts, alu_b is still driven with regs[rs2].
- The flag register is replaced wholesale by every ALU command, never OR-accumulated.
- dbg_data reflects writes from the cycle after the writeback edge.

Test Plan:
- Reset then dbg read of all entries -> 0x00; flag_q=0000; cmd_ready=1; rsp_valid=0.
- LD r1=0xFF, LD r2=0x01, ADD(000) rd=r3 rs1=r1 rs2=r2 -> rsp_data=0x00, rsp_flag=0111, regs[3]=0x00, rsp_valid 1 cycle after accept.
- LD r0=0x05, LD r1=0x07, SUB(001) rd=r0 rs1=r0 rs2=r1 -> rsp_data=0xFE, rsp_flag=1001, regs[0]=0xFE. A following LD leaves flag_q=1001.
- LD r2=0x81, SHL(111) rd=r2 rs1=r2 rs2=r2 -> rsp_data=0x02, flag=0001.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, cmd_ready=0, a cmd_valid pulse is ignored. Release -> IDLE, next command accepted.
- Assert rst_n=0 during EXEC of ADD r3 -> regs[3]=0, flag_q=0, rsp_valid never asserted, FSM IDLE after release.
